nios2e_pwm_out: RTL and testbench
=================================

NIOS2E_PWM_OUT -- requirements
Module: nios2e_pwm_out

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the PERIOD and DUTY registers and of the PWM counter.
REQ-002 Parameter RESET_PERIOD, default 0, SHALL set the reset value of the PERIOD shadow and active registers.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 address  input  2  SHALL be the Avalon-MM word address: 0 CTRL, 1 PERIOD, 2 DUTY, 3 STATUS.
REQ-006 chipselect  input  1  SHALL qualify every read and write access.
REQ-007 write_n  input  1  SHALL be the active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  SHALL carry write data; only the low bits named in REQ-013..REQ-016 are used.
REQ-009 readdata  output  32  SHALL return registered read data, zero-extended.
REQ-010 pwm_out  output  1  SHALL be the registered PWM waveform.

Function
REQ-011 readdata SHALL update every cycle, one cycle after address is presented, with no wait states.
REQ-012 Unused readdata bits SHALL read 0.
REQ-013 CTRL SHALL hold bit0 EN and bit1 POL (1 = active-low output); it is read/write.
REQ-014 PERIOD and DUTY writes SHALL load the shadow registers only; reads return the shadow values.
REQ-015 STATUS SHALL hold the following bits:
- bit0 PEND: read-only; 1 while a shadow differs from the active copy.
- bit1 WRAP: sticky; set at each terminal count; write-1-to-clear.
REQ-016 If a WRAP set and a clear write coincide, the set SHALL win.
REQ-017 With EN=1 and active period P>0, the counter SHALL run 0..P-1 and then wrap to 0.
REQ-018 Terminal count SHALL be the cycle in which the counter equals P-1.
REQ-019 At terminal count, the active copies SHALL load from the shadows.
REQ-020 A shadow write in the terminal-count cycle SHALL be captured into the active copy at that same edge.
REQ-021 The raw level SHALL be 1 when counter < active DUTY, else 0.
REQ-022 pwm_out SHALL equal raw XOR POL, registered one cycle after the counter value.
REQ-023 DUTY=0 SHALL give a constant inactive level; DUTY>=P SHALL give a constant active level (100%).
REQ-024 Active P=0 SHALL hold the counter at 0 and the output inactive.
REQ-025 While active P=0, the active copies SHALL load from the shadows every cycle.
REQ-026 While EN=0, the counter SHALL hold at 0, the active copies SHALL track the shadows every cycle, and pwm_out SHALL equal POL.
REQ-027 When EN goes 1, the first period SHALL start with the counter at 0 in the following cycle.
REQ-028 Clearing EN mid-period SHALL abort the period immediately; no completion is required.
REQ-029 Counter arithmetic SHALL be unsigned CNT_W-bit with no overflow beyond P-1.

Reset
REQ-030 On reset, the following SHALL apply:
- CTRL = 0.
- DUTY shadow and active = 0.
- PERIOD shadow and active = RESET_PERIOD.
- counter = 0; WRAP = 0.
- readdata = 0; pwm_out = 0.
REQ-031 Reset asserted mid-period SHALL take effect at the next clock edge and SHALL discard all pending shadow values.

Structure
REQ-032 Register addresses, CTRL and STATUS bit positions, and CNT_W SHALL live in a shared package, nios2e_pwm_pkg.
REQ-033 The counter, active registers and comparator SHALL be a sub-module, nios2e_pwm_core; the top level holds the Avalon register file.

Verification
REQ-034 Write PERIOD=10, DUTY=3, CTRL=1 -> pwm_out high for 3 cycles, low for 7, repeating; WRAP sets every 10 cycles.
REQ-035 Mid-period, write DUTY=7 -> current period still 3-high; PEND=1 until terminal count; next period 7-high; PEND=0 afterwards.
REQ-036 Run with DUTY=0, then DUTY=10, then DUTY=15 at PERIOD=10 -> constant low, constant high, constant high respectively.
REQ-037 Set CTRL=3 with PERIOD=4 and DUTY=1 -> pwm_out low 1 cycle, high 3; then CTRL=2 -> pwm_out held 1, counter 0.
REQ-038 Write DUTY=5 in the terminal-count cycle -> value 5 is used in the immediately following period.
REQ-039 Assert reset mid-period with PERIOD=8 -> next cycle pwm_out=0 and readdata=0, STATUS reads 0, PERIOD reads RESET_PERIOD.

Source files
------------

// File: rtl/nios2e_pwm_pkg.sv
// Shared definitions for the Nios II PWM output peripheral: register map,
// CTRL/STATUS bit positions and the default counter width.
package nios2e_pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_DUTY   = 2'd2,
        REG_STATUS = 2'd3
    } reg_addr_e;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_POL_BIT  = 1;
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_WRAP_BIT = 1;

    function automatic logic [31:0] ctrl_word(input logic en, input logic pol);
        logic [31:0] w;
        w = 32'd0;
        w[CTRL_EN_BIT]  = en;
        w[CTRL_POL_BIT] = pol;
        return w;
    endfunction

    function automatic logic [31:0] status_word(input logic pend, input logic wrap);
        logic [31:0] w;
        w = 32'd0;
        w[STAT_PEND_BIT] = pend;
        w[STAT_WRAP_BIT] = wrap;
        return w;
    endfunction

endpackage

// File: rtl/nios2e_pwm_out_if.sv
// Avalon-MM slave bus bundle for the PWM peripheral (no wait states, registered read data).
interface nios2e_pwm_out_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios2e_pwm_core.sv
// PWM engine: period counter, active PERIOD/DUTY copies and the duty comparator
// with a registered, polarity-adjusted output.
module nios2e_pwm_core
    import nios2e_pwm_pkg::*;
#(
    parameter int          CNT_W        = PWM_CNT_W,
    parameter int unsigned RESET_PERIOD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pol,
    input  logic [CNT_W-1:0] period_next,
    input  logic [CNT_W-1:0] duty_next,
    output logic [CNT_W-1:0] period_act,
    output logic [CNT_W-1:0] duty_act,
    output logic             term,
    output logic             pwm_out
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] period_act_r;
    logic [CNT_W-1:0] period_act_nxt_s;
    logic [CNT_W-1:0] duty_act_r;
    logic [CNT_W-1:0] duty_act_nxt_s;
    logic             running_s;
    logic             term_s;
    logic             raw_s;
    logic             pwm_r;

    assign running_s = en && (period_act_r != '0);
    assign term_s    = running_s && (cnt_r == (period_act_r - CNT_W'(1)));
    assign raw_s     = running_s && (cnt_r < duty_act_r);

    // Counter advance and active-copy reload; the next-shadow inputs already
    // include any write landing in this cycle, so a terminal-count write is captured.
    always_comb begin
        cnt_nxt_s        = '0;
        period_act_nxt_s = period_act_r;
        duty_act_nxt_s   = duty_act_r;
        if (running_s && !term_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = '0;
        end
        if (!running_s || term_s) begin
            period_act_nxt_s = period_next;
            duty_act_nxt_s   = duty_next;
        end else begin
            period_act_nxt_s = period_act_r;
            duty_act_nxt_s   = duty_act_r;
        end
    end

    // Core state registers and the output flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= '0;
            period_act_r <= CNT_W'(RESET_PERIOD);
            duty_act_r   <= '0;
            pwm_r        <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            period_act_r <= period_act_nxt_s;
            duty_act_r   <= duty_act_nxt_s;
            pwm_r        <= raw_s ^ pol;
        end
    end

    assign period_act = period_act_r;
    assign duty_act   = duty_act_r;
    assign term       = term_s;
    assign pwm_out    = pwm_r;

endmodule

// File: rtl/nios2e_pwm_out.sv
// Nios II PWM output peripheral: Avalon-MM register file (CTRL, PERIOD, DUTY,
// STATUS) in front of the nios2e_pwm_core engine.
module nios2e_pwm_out
    import nios2e_pwm_pkg::*;
#(
    parameter int          CNT_W        = PWM_CNT_W,
    parameter int unsigned RESET_PERIOD = 0
) (
    input  logic             clk,
    input  logic             reset,
    nios2e_pwm_out_if.slave  avs,
    output logic             pwm_out
);

    logic             wr_s;
    logic             en_r;
    logic             pol_r;
    logic             wrap_r;
    logic             wrap_nxt_s;
    logic             pend_s;
    logic             term_s;
    logic [CNT_W-1:0] period_sh_r;
    logic [CNT_W-1:0] duty_sh_r;
    logic [CNT_W-1:0] period_nxt_s;
    logic [CNT_W-1:0] duty_nxt_s;
    logic [CNT_W-1:0] period_act_s;
    logic [CNT_W-1:0] duty_act_s;
    logic [31:0]      rd_s;
    logic [31:0]      readdata_r;
    logic             unused_wdata_s;

    assign wr_s           = avs.chipselect && !avs.write_n;
    assign pend_s         = (period_sh_r != period_act_s) || (duty_sh_r != duty_act_s);
    assign unused_wdata_s = ^avs.writedata;

    // Shadow values as they will be after this edge, handed to the core for reload.
    always_comb begin
        period_nxt_s = period_sh_r;
        duty_nxt_s   = duty_sh_r;
        if (wr_s && (avs.address == REG_PERIOD)) begin
            period_nxt_s = avs.writedata[CNT_W-1:0];
        end else begin
            period_nxt_s = period_sh_r;
        end
        if (wr_s && (avs.address == REG_DUTY)) begin
            duty_nxt_s = avs.writedata[CNT_W-1:0];
        end else begin
            duty_nxt_s = duty_sh_r;
        end
    end

    // Sticky WRAP: a terminal count beats a simultaneous write-1-to-clear.
    always_comb begin
        wrap_nxt_s = wrap_r;
        if (term_s) begin
            wrap_nxt_s = 1'b1;
        end else if (wr_s && (avs.address == REG_STATUS) && avs.writedata[STAT_WRAP_BIT]) begin
            wrap_nxt_s = 1'b0;
        end else begin
            wrap_nxt_s = wrap_r;
        end
    end

    // Read multiplexer, zero-extended to the bus width.
    always_comb begin
        rd_s = 32'd0;
        case (avs.address)
            REG_CTRL:   rd_s = ctrl_word(en_r, pol_r);
            REG_PERIOD: rd_s = 32'(period_sh_r);
            REG_DUTY:   rd_s = 32'(duty_sh_r);
            REG_STATUS: rd_s = status_word(pend_s, wrap_r);
            default:    rd_s = 32'd0;
        endcase
    end

    // Register file and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r        <= 1'b0;
            pol_r       <= 1'b0;
            period_sh_r <= CNT_W'(RESET_PERIOD);
            duty_sh_r   <= '0;
            wrap_r      <= 1'b0;
            readdata_r  <= 32'd0;
        end else begin
            if (wr_s && (avs.address == REG_CTRL)) begin
                en_r  <= avs.writedata[CTRL_EN_BIT];
                pol_r <= avs.writedata[CTRL_POL_BIT];
            end
            period_sh_r <= period_nxt_s;
            duty_sh_r   <= duty_nxt_s;
            wrap_r      <= wrap_nxt_s;
            readdata_r  <= avs.chipselect ? rd_s : 32'd0;
        end
    end

    assign avs.readdata = readdata_r;

    nios2e_pwm_core #(
        .CNT_W        (CNT_W),
        .RESET_PERIOD (RESET_PERIOD)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .en          (en_r),
        .pol         (pol_r),
        .period_next (period_nxt_s),
        .duty_next   (duty_nxt_s),
        .period_act  (period_act_s),
        .duty_act    (duty_act_s),
        .term        (term_s),
        .pwm_out     (pwm_out)
    );

endmodule

// File: tb/tb_nios2e_pwm_out.sv
// Self-checking bench for nios2e_pwm_out: directed scenarios plus random bus
// traffic, all compared every cycle against a period/phase reference model.
module tb_nios2e_pwm_out;

    localparam int          CNT_W = 16;
    localparam int unsigned RST_P = 5;

    logic clk = 1'b0;
    logic reset;
    logic pwm_out;

    nios2e_pwm_out_if avs();

    nios2e_pwm_out #(.CNT_W(CNT_W), .RESET_PERIOD(RST_P)) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (avs),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: shadow/active settings, phase within the period, flags.
    bit          m_en, m_pol, m_wrap, m_pwm;
    int unsigned m_per_sh, m_duty_sh, m_per, m_duty, m_pos;
    logic [31:0] m_rd;
    bit          hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        m_en = 1'b0; m_pol = 1'b0; m_wrap = 1'b0; m_pwm = 1'b0;
        m_per_sh = RST_P; m_per = RST_P; m_duty_sh = 0; m_duty = 0; m_pos = 0;
        m_rd = 32'd0;
    endtask

    task automatic ref_step(input logic [1:0] a, input bit cs, input bit wr,
                            input logic [31:0] wd, input bit rst);
        bit live, last, pend;
        int unsigned ps, ds;
        if (rst) begin
            ref_reset();
            return;
        end
        pend = (m_per_sh != m_per) || (m_duty_sh != m_duty);
        if (!cs)          m_rd = 32'd0;
        else if (a == 0)  m_rd = {30'd0, m_pol, m_en};
        else if (a == 1)  m_rd = 32'(m_per_sh);
        else if (a == 2)  m_rd = 32'(m_duty_sh);
        else              m_rd = {30'd0, m_wrap, pend};
        live  = m_en && (m_per > 0);
        last  = live && (m_pos == m_per - 1);
        m_pwm = (live && (m_pos < m_duty)) ^ m_pol;
        ps = (wr && a == 1) ? 32'(wd[15:0]) : m_per_sh;
        ds = (wr && a == 2) ? 32'(wd[15:0]) : m_duty_sh;
        if (!live || last) begin
            m_per = ps; m_duty = ds; m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
        if (last)                          m_wrap = 1'b1;
        else if (wr && a == 3 && wd[1])    m_wrap = 1'b0;
        if (wr && a == 0) begin
            m_en = wd[0]; m_pol = wd[1];
        end
        m_per_sh = ps; m_duty_sh = ds;
    endtask

    task automatic cyc(input logic [1:0] a, input bit cs, input bit wr,
                       input logic [31:0] wd, input bit rst);
        avs.address = a; avs.chipselect = cs; avs.write_n = !wr;
        avs.writedata = wd; reset = rst;
        @(posedge clk);
        ref_step(a, cs, cs && wr, wd, rst);
        #1;
        chk("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
        chk("readdata", avs.readdata, m_rd);
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cyc(a, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(a, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic idle();
        rd_reg(2'd3);
    endtask

    task automatic run_collect(input int n);
        hist.delete();
        repeat (n) begin
            idle();
            hist.push_back(pwm_out);
        end
    endtask

    task automatic wait_pos(input int unsigned p);
        for (int k = 0; k < 40 && m_pos != p; k++) idle();
        chk("wait_phase", m_pos, p);
    endtask

    task automatic steady(input logic [31:0] duty, input bit lvl);
        wr_reg(2'd2, duty);
        wait_pos(9);
        idle();
        run_collect(20);
        for (int i = 0; i < 20; i++) chk("steady_level", {31'd0, hist[i]}, {31'd0, lvl});
    endtask

    initial begin
        logic [1:0]  ra;
        bit          rcs, rwr;
        logic [31:0] rwd;
        int unsigned low;

        avs.address = 2'd0; avs.chipselect = 1'b0; avs.write_n = 1'b1;
        avs.writedata = 32'd0; reset = 1'b1;
        ref_reset();
        @(negedge clk);
        cyc(2'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(2'd0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Reset values
        rd_reg(2'd1); chk("reset_period", avs.readdata, 32'd5);
        rd_reg(2'd3); chk("reset_status", avs.readdata, 32'd0);
        rd_reg(2'd0); chk("reset_ctrl", avs.readdata, 32'd0);
        chk("reset_pwm", {31'd0, pwm_out}, 32'd0);

        // PERIOD=10 DUTY=3: 3 high / 7 low, WRAP sets
        wr_reg(2'd1, 32'd10); wr_reg(2'd2, 32'd3); wr_reg(2'd0, 32'd1);
        run_collect(30);
        for (int i = 0; i < 30; i++) chk("duty3_pattern", {31'd0, hist[i]}, {31'd0, ((i % 10) < 3)});
        rd_reg(2'd3); chk("wrap_set", {31'd0, avs.readdata[1]}, 32'd1);
        wait_pos(4);
        wr_reg(2'd3, 32'd2);
        rd_reg(2'd3); chk("wrap_cleared", {31'd0, avs.readdata[1]}, 32'd0);

        // Mid-period DUTY=7 stays pending until terminal count
        wait_pos(2);
        wr_reg(2'd2, 32'd7);
        rd_reg(2'd3); chk("pend_set", {31'd0, avs.readdata[0]}, 32'd1);
        wait_pos(0);
        run_collect(10);
        for (int i = 0; i < 10; i++) chk("duty7_pattern", {31'd0, hist[i]}, {31'd0, (i < 7)});
        rd_reg(2'd3); chk("pend_clear", {31'd0, avs.readdata[0]}, 32'd0);

        // Write DUTY=5 in the terminal-count cycle
        wait_pos(9);
        wr_reg(2'd2, 32'd5);
        run_collect(10);
        for (int i = 0; i < 10; i++) chk("tc_write_pattern", {31'd0, hist[i]}, {31'd0, (i < 5)});

        // Duty extremes at PERIOD=10
        steady(32'd0, 1'b0);
        steady(32'd10, 1'b1);
        steady(32'd15, 1'b1);

        // Active-low output, then disabled with POL=1
        wr_reg(2'd0, 32'd0); wr_reg(2'd1, 32'd4); wr_reg(2'd2, 32'd1); wr_reg(2'd0, 32'd3);
        run_collect(8);
        for (int i = 0; i < 8; i++) chk("pol_pattern", {31'd0, hist[i]}, {31'd0, ((i % 4) >= 1)});
        wr_reg(2'd0, 32'd2);
        run_collect(6);
        for (int i = 0; i < 6; i++) chk("disabled_pol", {31'd0, hist[i]}, 32'd1);

        // Random bus traffic against the model
        for (int i = 0; i < 500; i++) begin
            ra  = 2'($urandom_range(0, 3));
            rcs = ($urandom_range(0, 3) != 0);
            rwr = ($urandom_range(0, 1) != 0);
            if (ra == 2'd0 && $urandom_range(0, 3) != 0) rwr = 1'b0;
            case (ra)
                2'd0:    low = $urandom_range(0, 3);
                2'd1:    low = $urandom_range(0, 12);
                2'd2:    low = $urandom_range(0, 14);
                default: low = $urandom_range(0, 3);
            endcase
            rwd = ($urandom() & 32'hFFFF_0000) | low;
            cyc(ra, rcs, rwr, rwd, ($urandom_range(0, 99) == 0));
        end

        // Reset mid-period discards pending shadows
        wr_reg(2'd0, 32'd0); wr_reg(2'd1, 32'd8); wr_reg(2'd2, 32'd3); wr_reg(2'd0, 32'd1);
        repeat (4) idle();
        wr_reg(2'd1, 32'd9);
        cyc(2'd3, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_readdata", avs.readdata, 32'd0);
        rd_reg(2'd3); chk("rst_status", avs.readdata, 32'd0);
        rd_reg(2'd1); chk("rst_period", avs.readdata, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
